// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI-Lite register slice.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    SLICE_BYPASS = 2'd0,
    SLICE_FWD    = 2'd1,
    SLICE_SKID   = 2'd2
  } slice_mode_e;

  localparam int unsigned PROT_WIDTH = 3;
  localparam int unsigned RESP_WIDTH = 2;

  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_WIDTH-1:0] RESP_EXOKAY = 2'b01;
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_WIDTH-1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_channel.sv
// AXI-Lite link bundle: five valid/ready channels with manager/subordinate views.
interface axi_lite_channel
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                    aw_valid;
  logic                    aw_ready;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [PROT_WIDTH-1:0]   aw_prot;
  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    b_valid;
  logic                    b_ready;
  logic [RESP_WIDTH-1:0]   b_resp;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [PROT_WIDTH-1:0]   ar_prot;
  logic                    r_valid;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [RESP_WIDTH-1:0]   r_resp;

  modport master (
    output aw_valid, aw_addr, aw_prot, input aw_ready,
    output w_valid, w_data, w_strb, input w_ready,
    input b_valid, b_resp, output b_ready,
    output ar_valid, ar_addr, ar_prot, input ar_ready,
    input r_valid, r_data, r_resp, output r_ready
  );

  modport slave (
    input aw_valid, aw_addr, aw_prot, output aw_ready,
    input w_valid, w_data, w_strb, output w_ready,
    output b_valid, b_resp, input b_ready,
    input ar_valid, ar_addr, ar_prot, output ar_ready,
    output r_valid, r_data, r_resp, input r_ready
  );

endinterface

// File: rtl/axi_lite_slice_chan.sv
// Generic valid/ready buffer: bypass wire, forward register, or two-entry skid buffer.
module axi_lite_slice_chan
  import axi_lite_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned MODE  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  if (MODE == 32'(SLICE_BYPASS)) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign out_valid      = in_valid;
    assign out_data       = in_data;
    assign in_ready       = out_ready;

  end else if (MODE == 32'(SLICE_FWD)) begin : g_fwd
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q;
    logic             load_c;

    assign in_ready = !valid_q || out_ready;
    assign load_c   = in_valid && in_ready;

    always_comb begin
      valid_d = valid_q;
      if (load_c)         valid_d = 1'b1;
      else if (out_ready) valid_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) valid_q <= 1'b0;
      else     valid_q <= valid_d;
    end

    // Payload is don't-care while invalid, so it carries no reset.
    always_ff @(posedge clk) begin
      if (load_c) data_q <= in_data;
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

  end else if (MODE == 32'(SLICE_SKID)) begin : g_skid
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             accept_c;

    assign accept_c = in_valid && ready_q;

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
        ST_EMPTY: begin
          if (accept_c) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (accept_c && out_ready) begin
            main_d = in_data;
          end else if (accept_c) begin
            state_d = ST_TWO;
            skid_d  = in_data;
          end else if (out_ready) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_ready) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
      // Both handshake outputs are decoded from the next state so they leave flops.
      ready_d = (state_d != ST_TWO);
      valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_EMPTY;
        ready_q <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        state_q <= state_d;
        ready_q <= ready_d;
        valid_q <= valid_d;
      end
    end

    always_ff @(posedge clk) begin
      main_q <= main_d;
      skid_q <= skid_d;
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_data  = main_q;

  end else begin : g_bad_mode
    $fatal(1, "axi_lite_slice_chan: MODE %0d is not 0, 1 or 2", MODE);
  end

endmodule

// File: rtl/axi_lite_reg_slice.sv
// Register slice for one AXI-Lite link; each channel gets an independently configured buffer.
module axi_lite_reg_slice
  import axi_lite_pkg::*;
#(
  parameter int unsigned AW_MODE = 2,
  parameter int unsigned W_MODE  = 2,
  parameter int unsigned B_MODE  = 2,
  parameter int unsigned AR_MODE = 2,
  parameter int unsigned R_MODE  = 2
) (
  input logic             clk,
  input logic             rst,
  axi_lite_channel.slave  master,
  axi_lite_channel.master slave
);

  localparam int unsigned ADDR_W = master.ADDR_WIDTH;
  localparam int unsigned DATA_W = master.DATA_WIDTH;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned AX_W   = ADDR_W + PROT_WIDTH;
  localparam int unsigned WD_W   = DATA_W + STRB_W;
  localparam int unsigned B_W    = RESP_WIDTH;
  localparam int unsigned R_W    = DATA_W + RESP_WIDTH;

  if (master.ADDR_WIDTH != slave.ADDR_WIDTH || master.DATA_WIDTH != slave.DATA_WIDTH)
  begin : g_width_chk
    $fatal(1, "axi_lite_reg_slice: master and slave widths differ");
  end

  logic [AX_W-1:0] aw_out;
  logic [WD_W-1:0] w_out;
  logic [B_W-1:0]  b_out;
  logic [AX_W-1:0] ar_out;
  logic [R_W-1:0]  r_out;

  assign {slave.aw_addr, slave.aw_prot} = aw_out;
  assign {slave.w_data, slave.w_strb}   = w_out;
  assign master.b_resp                  = b_out;
  assign {slave.ar_addr, slave.ar_prot} = ar_out;
  assign {master.r_data, master.r_resp} = r_out;

  // Request channels flow manager -> subordinate.
  axi_lite_slice_chan #(.WIDTH(AX_W), .MODE(AW_MODE)) u_aw (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (master.aw_valid),
    .in_ready  (master.aw_ready),
    .in_data   ({master.aw_addr, master.aw_prot}),
    .out_valid (slave.aw_valid),
    .out_ready (slave.aw_ready),
    .out_data  (aw_out)
  );

  axi_lite_slice_chan #(.WIDTH(WD_W), .MODE(W_MODE)) u_w (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (master.w_valid),
    .in_ready  (master.w_ready),
    .in_data   ({master.w_data, master.w_strb}),
    .out_valid (slave.w_valid),
    .out_ready (slave.w_ready),
    .out_data  (w_out)
  );

  axi_lite_slice_chan #(.WIDTH(AX_W), .MODE(AR_MODE)) u_ar (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (master.ar_valid),
    .in_ready  (master.ar_ready),
    .in_data   ({master.ar_addr, master.ar_prot}),
    .out_valid (slave.ar_valid),
    .out_ready (slave.ar_ready),
    .out_data  (ar_out)
  );

  // Response channels flow subordinate -> manager.
  axi_lite_slice_chan #(.WIDTH(B_W), .MODE(B_MODE)) u_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (slave.b_valid),
    .in_ready  (slave.b_ready),
    .in_data   (slave.b_resp),
    .out_valid (master.b_valid),
    .out_ready (master.b_ready),
    .out_data  (b_out)
  );

  axi_lite_slice_chan #(.WIDTH(R_W), .MODE(R_MODE)) u_r (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (slave.r_valid),
    .in_ready  (slave.r_ready),
    .in_data   ({slave.r_data, slave.r_resp}),
    .out_valid (master.r_valid),
    .out_ready (master.r_ready),
    .out_data  (r_out)
  );

endmodule

// File: tb/tb_axi_lite_reg_slice.sv
// Self-checking bench for axi_lite_reg_slice: vector table, directed corner cases, random scoreboard run.
module tb_axi_lite_reg_slice;
  import axi_lite_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m2 (), s2 (), mm (), sm ();

  axi_lite_reg_slice #(.AW_MODE(2), .W_MODE(2), .B_MODE(2), .AR_MODE(2), .R_MODE(2)) u_dut (
    .clk(clk), .rst(rst), .master(m2.slave), .slave(s2.master));

  axi_lite_reg_slice #(.AW_MODE(0), .W_MODE(1), .B_MODE(2), .AR_MODE(2), .R_MODE(2)) u_mix (
    .clk(clk), .rst(rst), .master(mm.slave), .slave(sm.master));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard on the all-skid instance ----------------
  logic [63:0] q_aw[$], q_w[$], q_b[$], q_ar[$], q_r[$];
  int          out_cnt[5];
  logic [4:0]  hs_in = '0;
  logic [4:0]  hold_v = '0;
  logic [63:0] hold_d[5];
  logic        sb_en = 1'b0;
  string       chn[5] = '{"aw", "w", "b", "ar", "r"};

  function automatic void sb_push(input int ch, input logic [63:0] d);
    case (ch)
      0: q_aw.push_back(d);
      1: q_w.push_back(d);
      2: q_b.push_back(d);
      3: q_ar.push_back(d);
      default: q_r.push_back(d);
    endcase
  endfunction

  function automatic int sb_size(input int ch);
    case (ch)
      0: return q_aw.size();
      1: return q_w.size();
      2: return q_b.size();
      3: return q_ar.size();
      default: return q_r.size();
    endcase
  endfunction

  function automatic logic [63:0] sb_pop(input int ch);
    case (ch)
      0: return q_aw.pop_front();
      1: return q_w.pop_front();
      2: return q_b.pop_front();
      3: return q_ar.pop_front();
      default: return q_r.pop_front();
    endcase
  endfunction

  always @(negedge clk) begin : mon
    logic [4:0]  iv, ir, ov, ordy;
    logic [63:0] id[5];
    logic [63:0] od[5];
    iv[0] = m2.aw_valid; ir[0] = m2.aw_ready; id[0] = 64'({m2.aw_addr, m2.aw_prot});
    ov[0] = s2.aw_valid; ordy[0] = s2.aw_ready; od[0] = 64'({s2.aw_addr, s2.aw_prot});
    iv[1] = m2.w_valid; ir[1] = m2.w_ready; id[1] = 64'({m2.w_data, m2.w_strb});
    ov[1] = s2.w_valid; ordy[1] = s2.w_ready; od[1] = 64'({s2.w_data, s2.w_strb});
    iv[2] = s2.b_valid; ir[2] = s2.b_ready; id[2] = 64'(s2.b_resp);
    ov[2] = m2.b_valid; ordy[2] = m2.b_ready; od[2] = 64'(m2.b_resp);
    iv[3] = m2.ar_valid; ir[3] = m2.ar_ready; id[3] = 64'({m2.ar_addr, m2.ar_prot});
    ov[3] = s2.ar_valid; ordy[3] = s2.ar_ready; od[3] = 64'({s2.ar_addr, s2.ar_prot});
    iv[4] = s2.r_valid; ir[4] = s2.r_ready; id[4] = 64'({s2.r_data, s2.r_resp});
    ov[4] = m2.r_valid; ordy[4] = m2.r_ready; od[4] = 64'({m2.r_data, m2.r_resp});
    hs_in <= iv & ir;
    for (int ch = 0; ch < 5; ch++) begin
      if (sb_en && !rst) begin
        if (iv[ch] && ir[ch]) sb_push(ch, id[ch]);
        if (ov[ch] && ordy[ch]) begin
          out_cnt[ch]++;
          if (sb_size(ch) == 0) check($sformatf("sb_extra_%s", chn[ch]), od[ch], 64'hBAD);
          else                  check($sformatf("sb_data_%s", chn[ch]), od[ch], sb_pop(ch));
        end
        if (hold_v[ch])
          check($sformatf("stable_%s", chn[ch]), 64'(ov[ch] && od[ch] == hold_d[ch]), 64'd1);
        hold_v[ch] <= ov[ch] && !ordy[ch];
        hold_d[ch] <= od[ch];
      end else begin
        hold_v[ch] <= 1'b0;
      end
    end
  end

  task automatic idle_all();
    m2.aw_valid = 0; m2.aw_addr = '0; m2.aw_prot = '0;
    m2.w_valid = 0; m2.w_data = '0; m2.w_strb = '0;
    m2.ar_valid = 0; m2.ar_addr = '0; m2.ar_prot = '0;
    m2.b_ready = 1; m2.r_ready = 1;
    s2.b_valid = 0; s2.b_resp = '0; s2.r_valid = 0; s2.r_data = '0; s2.r_resp = '0;
    s2.aw_ready = 1; s2.w_ready = 1; s2.ar_ready = 1;
    mm.aw_valid = 0; mm.aw_addr = '0; mm.aw_prot = '0;
    mm.w_valid = 0; mm.w_data = '0; mm.w_strb = '0;
    mm.ar_valid = 0; mm.ar_addr = '0; mm.ar_prot = '0;
    mm.b_ready = 1; mm.r_ready = 1;
    sm.b_valid = 0; sm.b_resp = '0; sm.r_valid = 0; sm.r_data = '0; sm.r_resp = '0;
    sm.aw_ready = 1; sm.w_ready = 1; sm.ar_ready = 1;
  endtask

  task automatic check_drained(input string tag);
    for (int ch = 0; ch < 5; ch++)
      check($sformatf("%s_left_%s", tag, chn[ch]), 64'(sb_size(ch)), 64'd0);
  endtask

  // ---------------- vector table for the single write ----------------
  typedef struct {
    logic        aw_v;  logic [31:0] aw_a;
    logic        w_v;   logic [31:0] w_d;  logic [3:0] w_s;
    logic        b_v;   logic [1:0]  b_r;
    logic        x_aw_v; logic [31:0] x_aw_a;
    logic        x_w_v;  logic [31:0] x_w_d; logic [3:0] x_w_s;
    logic        x_b_v;  logic [1:0]  x_b_r;
    logic        x_aw_rdy;
  } vec_t;

  vec_t tbl[10];

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          sent, start_cnt, total0, total, ncyc;
    logic [31:0] stab_d;

    tbl[0] = '{1, 32'h10, 1, 32'hDEADBEEF, 4'hF, 0, RESP_OKAY,   0, 0,     0, 0, 0,            0, RESP_OKAY,   1};
    tbl[1] = '{0, 0,      0, 0,            0,    0, RESP_OKAY,   1, 32'h10, 1, 32'hDEADBEEF, 4'hF, 0, RESP_OKAY, 1};
    tbl[2] = '{0, 0,      0, 0,            0,    0, RESP_OKAY,   0, 0,     0, 0, 0,            0, RESP_OKAY,   1};
    tbl[3] = tbl[2];
    tbl[4] = tbl[2];
    tbl[5] = '{0, 0,      0, 0,            0,    1, RESP_OKAY,   0, 0,     0, 0, 0,            0, RESP_OKAY,   1};
    tbl[6] = '{0, 0,      0, 0,            0,    0, RESP_OKAY,   0, 0,     0, 0, 0,            1, RESP_OKAY,   1};
    tbl[7] = '{0, 0,      0, 0,            0,    1, RESP_SLVERR, 0, 0,     0, 0, 0,            0, RESP_OKAY,   1};
    tbl[8] = '{0, 0,      0, 0,            0,    0, RESP_OKAY,   0, 0,     0, 0, 0,            1, RESP_SLVERR, 1};
    tbl[9] = tbl[2];

    idle_all();

    // Reset state: outputs low, skid in_ready held low while rst is high.
    @(negedge clk);
    check("rst_slave_aw_valid", s2.aw_valid, 0);
    check("rst_slave_w_valid", s2.w_valid, 0);
    check("rst_master_b_valid", m2.b_valid, 0);
    check("rst_master_r_valid", m2.r_valid, 0);
    check("rst_aw_ready", m2.aw_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_aw_ready_before_edge", m2.aw_ready, 0);
    cyc();
    check("rst_aw_ready_after_edge", m2.aw_ready, 1);
    sb_en = 1'b1;

    // Single write through the table.
    for (int i = 0; i < 10; i++) begin
      if (i != 0) cyc();
      m2.aw_valid = tbl[i].aw_v; m2.aw_addr = tbl[i].aw_a; m2.aw_prot = '0;
      m2.w_valid = tbl[i].w_v;  m2.w_data = tbl[i].w_d;  m2.w_strb = tbl[i].w_s;
      s2.b_valid = tbl[i].b_v;  s2.b_resp = tbl[i].b_r;
      @(negedge clk);
      check($sformatf("t1_aw_valid[%0d]", i), s2.aw_valid, tbl[i].x_aw_v);
      if (tbl[i].x_aw_v) check($sformatf("t1_aw_addr[%0d]", i), s2.aw_addr, tbl[i].x_aw_a);
      check($sformatf("t1_w_valid[%0d]", i), s2.w_valid, tbl[i].x_w_v);
      if (tbl[i].x_w_v) begin
        check($sformatf("t1_w_data[%0d]", i), s2.w_data, tbl[i].x_w_d);
        check($sformatf("t1_w_strb[%0d]", i), s2.w_strb, tbl[i].x_w_s);
      end
      check($sformatf("t1_b_valid[%0d]", i), m2.b_valid, tbl[i].x_b_v);
      if (tbl[i].x_b_v) check($sformatf("t1_b_resp[%0d]", i), m2.b_resp, tbl[i].x_b_r);
      check($sformatf("t1_aw_ready[%0d]", i), m2.aw_ready, tbl[i].x_aw_rdy);
    end
    cyc(); idle_all();

    // AR backpressure: two beats fill the skid, third waits.
    cyc(); s2.ar_ready = 0; m2.ar_valid = 1; m2.ar_addr = 32'h0;
    @(negedge clk); check("t2_ready_c0", m2.ar_ready, 1);
    cyc(); m2.ar_addr = 32'h4;
    @(negedge clk); check("t2_ready_c1", m2.ar_ready, 1);
    check("t2_slave_addr_c1", s2.ar_addr, 32'h0);
    cyc(); m2.ar_addr = 32'h8;
    @(negedge clk); check("t2_ready_c2", m2.ar_ready, 0);
    cyc();
    @(negedge clk); check("t2_ready_c3", m2.ar_ready, 0);
    check("t2_slave_valid_c3", s2.ar_valid, 1);
    cyc(); s2.ar_ready = 1;
    @(negedge clk); check("t2_out0", s2.ar_addr, 32'h0);
    cyc();
    @(negedge clk); check("t2_out1", s2.ar_addr, 32'h4);
    check("t2_ready_refill", m2.ar_ready, 1);
    cyc(); m2.ar_valid = 0;
    @(negedge clk); check("t2_out2", s2.ar_addr, 32'h8);
    check("t2_out2_valid", s2.ar_valid, 1);
    cyc();
    @(negedge clk); check("t2_done_valid", s2.ar_valid, 0);

    // R streaming: 64 beats within 65 cycles.
    start_cnt = out_cnt[4];
    sent = 0;
    for (int k = 0; k < 65; k++) begin
      cyc();
      if (sent < 64) begin
        s2.r_valid = 1; s2.r_data = $urandom; s2.r_resp = 2'($urandom_range(3));
      end else begin
        s2.r_valid = 0;
      end
      @(negedge clk);
      if (s2.r_valid && s2.r_ready) sent++;
    end
    #1;
    check("t3_beats_out", 64'(out_cnt[4] - start_cnt), 64'd64);
    cyc(); idle_all();
    repeat (4) cyc();
    check_drained("t123");

    // Asynchronous reset pulse with two W beats held.
    cyc(); s2.w_ready = 0; m2.w_valid = 1; m2.w_data = 32'hA1A1A1A1; m2.w_strb = 4'hF;
    cyc(); m2.w_data = 32'hB2B2B2B2;
    cyc(); m2.w_valid = 0;
    @(negedge clk);
    check("t4_two_ready", m2.w_ready, 0);
    check("t4_two_data", s2.w_data, 32'hA1A1A1A1);
    sb_en = 1'b0;
    #1 rst = 1'b1;
    #1 check("t4_rst_w_valid", s2.w_valid, 0);
    check("t4_rst_w_ready", m2.w_ready, 0);
    #1 rst = 1'b0;
    #1 check("t4_rel_w_ready", m2.w_ready, 0);
    @(posedge clk); #1;
    check("t4_edge_w_ready", m2.w_ready, 1);
    s2.w_ready = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); check($sformatf("t4_no_stale[%0d]", k), s2.w_valid, 0);
      cyc();
    end
    q_aw.delete(); q_w.delete(); q_b.delete(); q_ar.delete(); q_r.delete();

    // Mode mix: AW bypass, W forward register.
    cyc(); sm.aw_ready = 1; sm.w_ready = 0;
    mm.aw_valid = 1; mm.aw_addr = 32'h20; mm.w_valid = 1; mm.w_data = 32'h12345678; mm.w_strb = 4'h3;
    @(negedge clk);
    check("t5_aw_same_cycle", sm.aw_valid, 1);
    check("t5_aw_addr", sm.aw_addr, 32'h20);
    check("t5_aw_ready_pass", mm.aw_ready, 1);
    check("t5_w_not_yet", sm.w_valid, 0);
    check("t5_w_ready_empty", mm.w_ready, 1);
    cyc(); mm.aw_valid = 0; mm.w_valid = 0; mm.w_data = 32'hFFFFFFFF; sm.aw_ready = 0;
    @(negedge clk);
    check("t5_aw_dropped", sm.aw_valid, 0);
    check("t5_aw_ready_follow", mm.aw_ready, 0);
    check("t5_w_ready_full", mm.w_ready, 0);
    stab_d = 32'h12345678;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) cyc();
      if (k != 0) @(negedge clk);
      check($sformatf("t5_w_valid_hold[%0d]", k), sm.w_valid, 1);
      check($sformatf("t5_w_data_hold[%0d]", k), sm.w_data, stab_d);
      check($sformatf("t5_w_strb_hold[%0d]", k), sm.w_strb, 4'h3);
    end
    cyc(); sm.w_ready = 1;
    @(negedge clk);
    check("t5_w_ready_comb", mm.w_ready, 1);
    cyc();
    @(negedge clk); check("t5_w_drained", sm.w_valid, 0);
    cyc(); idle_all();

    // Random valid/ready on every channel of the skid instance.
    sb_en = 1'b1;
    total0 = out_cnt[0] + out_cnt[1] + out_cnt[2] + out_cnt[3] + out_cnt[4];
    total = 0;
    ncyc = 0;
    while (total < 10000 && ncyc < 30000) begin
      cyc();
      ncyc++;
      if (!m2.aw_valid || hs_in[0]) begin
        m2.aw_valid = ($urandom_range(99) < 70); m2.aw_addr = $urandom; m2.aw_prot = 3'($urandom);
      end
      if (!m2.w_valid || hs_in[1]) begin
        m2.w_valid = ($urandom_range(99) < 70); m2.w_data = $urandom; m2.w_strb = 4'($urandom);
      end
      if (!s2.b_valid || hs_in[2]) begin
        s2.b_valid = ($urandom_range(99) < 70); s2.b_resp = 2'($urandom);
      end
      if (!m2.ar_valid || hs_in[3]) begin
        m2.ar_valid = ($urandom_range(99) < 70); m2.ar_addr = $urandom; m2.ar_prot = 3'($urandom);
      end
      if (!s2.r_valid || hs_in[4]) begin
        s2.r_valid = ($urandom_range(99) < 70); s2.r_data = $urandom; s2.r_resp = 2'($urandom);
      end
      s2.aw_ready = ($urandom_range(99) < 65);
      s2.w_ready  = ($urandom_range(99) < 65);
      m2.b_ready  = ($urandom_range(99) < 65);
      s2.ar_ready = ($urandom_range(99) < 65);
      m2.r_ready  = ($urandom_range(99) < 65);
      @(negedge clk); #1;
      total = out_cnt[0] + out_cnt[1] + out_cnt[2] + out_cnt[3] + out_cnt[4] - total0;
    end
    check("t6_beat_budget", 64'(total >= 10000), 64'd1);
    cyc();
    m2.aw_valid = 0; m2.w_valid = 0; m2.ar_valid = 0; s2.b_valid = 0; s2.r_valid = 0;
    s2.aw_ready = 1; s2.w_ready = 1; s2.ar_ready = 1; m2.b_ready = 1; m2.r_ready = 1;
    repeat (6) cyc();
    check_drained("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
